// File: rtl/sc_pkg.sv
// sc_pkg: shared FSM state type and default window width for the stochastic-to-binary converter.
package sc_pkg;
    typedef enum logic [1:0] {IDLE, COUNT, DONE} sc_state_e;
    localparam int SC_WIDTH = 8;
endpackage

// File: rtl/sc_window_cnt.sv
// sc_window_cnt: counts enabled cycles of a 2^WIDTH window; last flags the final enabled cycle.
module sc_window_cnt #(
    parameter int WIDTH = sc_pkg::SC_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clear ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign last = enable && (cnt_q == '1);
endmodule

// File: rtl/sc_stoch_to_bin.sv
// sc_stoch_to_bin: counts ones of a bitstream over a 2^WIDTH-cycle window with valid/ready output.
// Define SC_ADDER_RESCALE_EN to double the result (saturating at 2^WIDTH) to undo sc_adder's 1/2 scaling.
module sc_stoch_to_bin
    import sc_pkg::*;
#(
    parameter int WIDTH = SC_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           bit_in,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WIDTH:0] result
);
    sc_state_e      state_q, state_d;
    logic [WIDTH:0] count_q, count_d, result_q, result_d, sum, res_w;
    logic           busy_q, busy_d, valid_q, valid_d;
    logic           clear, enable, last;

    sc_window_cnt #(.WIDTH(WIDTH)) u_win (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .enable (enable),
        .last   (last)
    );

    assign sum = count_q + {{WIDTH{1'b0}}, bit_in};

`ifdef SC_ADDER_RESCALE_EN
    localparam logic [WIDTH+1:0] FULL = (WIDTH+2)'(1) << WIDTH;
    logic [WIDTH+1:0] dbl;
    assign dbl   = {sum, 1'b0};
    assign res_w = (dbl > FULL) ? FULL[WIDTH:0] : dbl[WIDTH:0];
`else
    assign res_w = sum;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        clear    = 1'b0;
        enable   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = COUNT;
                count_d = '0;
                clear   = 1'b1;
                busy_d  = 1'b1;
            end
            COUNT: begin
                enable  = 1'b1;
                count_d = sum;
                if (last) begin
                    state_d  = DONE;
                    result_d = res_w;
                    busy_d   = 1'b0;
                    valid_d  = 1'b1;
                end
            end
            DONE: if (out_ready) begin
                // a start on the accepting edge chains straight into the next window
                state_d = start ? COUNT : IDLE;
                valid_d = 1'b0;
                busy_d  = start;
                clear   = start;
                count_d = start ? '0 : count_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign result    = result_q;
endmodule

// File: tb/tb_sc_stoch_to_bin.sv
// tb_sc_stoch_to_bin: directed and random windows for WIDTH=4 against a ones-counting model.
module tb_sc_stoch_to_bin;
    localparam int W = 4;
    localparam int N = 16;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, bit_in = 1'b0, out_ready = 1'b0;
    logic         busy, out_valid;
    logic [W:0]   result;
    int           errors = 0, checks = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sc_stoch_to_bin #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_in    (bit_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    function automatic int model(input int ones);
`ifdef SC_ADDER_RESCALE_EN
        return (2 * ones > N) ? N : 2 * ones;
`else
        return ones;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input logic [N-1:0] pat, input int hold, input string tag);
        int ones;
        ones = $countones(pat);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " busy_start"}, 32'(busy), 1);
        chk({tag, " valid_start"}, 32'(out_valid), 0);
        for (int i = 0; i < N; i++) begin
            bit_in = pat[i];
            tick();
            if (i == 7) chk({tag, " busy_mid"}, 32'(busy), 1);
        end
        chk({tag, " valid"}, 32'(out_valid), 1);
        chk({tag, " busy_done"}, 32'(busy), 0);
        chk({tag, " result"}, 32'(result), model(ones));
        out_ready = 1'b0;
        start = 1'b1;
        for (int k = 0; k < hold; k++) begin
            bit_in = ~bit_in;
            tick();
            chk({tag, " hold_valid"}, 32'(out_valid), 1);
            chk({tag, " hold_result"}, 32'(result), model(ones));
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " valid_after"}, 32'(out_valid), 0);
        chk({tag, " busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        int ones, last_v;
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_result", 32'(result), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        run_window(16'hFFFF, 0, "all_ones");
        run_window(16'h5555, 0, "alternating");
        run_window(16'h0000, 0, "all_zero");
        run_window(16'h001F, 0, "five_ones");
        run_window(16'h0FFF, 0, "twelve_ones");
        run_window(16'h3C96, 5, "backpressure");
        for (int r = 0; r < 4; r++)
            run_window(16'($urandom), int'($urandom_range(0, 3)), "random");

        start = 1'b1;
        out_ready = 1'b1;
        tick();
        last_v = -1;
        for (int w = 0; w < 3; w++) begin
            ones = 0;
            for (int i = 0; i < N; i++) begin
                bit_in = 1'($urandom_range(0, 1));
                ones += int'(bit_in);
                tick();
                if (i == 7) chk("b2b_valid_mid", 32'(out_valid), 0);
            end
            chk("b2b_valid", 32'(out_valid), 1);
            chk("b2b_result", 32'(result), model(ones));
            if (last_v >= 0) chk("b2b_period", 32'(cyc - last_v), 17);
            last_v = cyc;
            bit_in = 1'($urandom_range(0, 1));
            tick();
            chk("b2b_restart_valid", 32'(out_valid), 0);
            chk("b2b_restart_busy", 32'(busy), 1);
        end
        start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bit_in = 1'b1;
            tick();
        end
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_result", 32'(result), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_idle_valid", 32'(out_valid), 0);
        run_window(16'($urandom), 1, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
